// File: rtl/anycore_encoder_pkg.sv
// Shared constants for the L1.5 -> AnyCore response encoder: response codes,
// block geometry and the FSM state type.
package anycore_encoder_pkg;

    localparam int unsigned ICACHE_BLOCK_ADDR_BITS = 26;
    localparam int unsigned RESP_DATA_BITS         = 256;

    // L1.5 return types
    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] INV_RET   = 4'b0011;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;
    localparam logic [3:0] EVICT_REQ = 4'b1111;

    typedef enum logic [1:0] {
        WAIT_INT = 2'd0,
        IDLE     = 2'd1,
        ACK      = 2'd2
    } enc_state_e;

    function automatic logic [RESP_DATA_BITS-1:0] pack_resp(
        input logic [63:0] d0,
        input logic [63:0] d1,
        input logic [63:0] d2,
        input logic [63:0] d3
    );
        return {d3, d2, d1, d0};
    endfunction

endpackage

// File: rtl/anycore_fill_tracker.sv
// Tracks the single outstanding I-cache miss: latched block address plus a
// pending flag, with a new request beating a same-cycle fill completion.
module anycore_fill_tracker
    import anycore_encoder_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_set,
    input  logic [ICACHE_BLOCK_ADDR_BITS-1:0] req_addr,
    input  logic                              fill_clr,
    output logic                              pending,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] miss_addr
);

    logic accept;

    // A request is only taken when the slot is free or is being freed this cycle.
    always_comb begin
        accept = req_set && (!pending || fill_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            miss_addr <= '0;
        end else if (accept) begin
            pending   <= 1'b1;
            miss_addr <= req_addr;
        end else if (fill_clr) begin
            pending   <= 1'b0;
        end
    end

endmodule

// File: rtl/anycore_encoder.sv
// Converts L1.5 responses into AnyCore I-fill / load / store-ack pulses and
// releases the core from reset once the wake-up interrupt arrives.
module anycore_encoder
    import anycore_encoder_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              l15_transducer_val,
    input  logic [3:0]                        l15_transducer_returntype,
    input  logic [63:0]                       l15_transducer_data_0,
    input  logic [63:0]                       l15_transducer_data_1,
    input  logic [63:0]                       l15_transducer_data_2,
    input  logic [63:0]                       l15_transducer_data_3,
    input  logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_ic2mem_reqaddr,
    input  logic                              anycore_ic2mem_reqvalid,
    output logic                              transducer_l15_req_ack,
    output logic                              anycore_mem2ic_respvalid,
    output logic [ICACHE_BLOCK_ADDR_BITS-1:0] anycore_mem2ic_respaddr,
    output logic [RESP_DATA_BITS-1:0]         anycore_mem2ic_data,
    output logic                              anycore_mem2dc_ldvalid,
    output logic [RESP_DATA_BITS-1:0]         anycore_mem2dc_lddata,
    output logic                              anycore_mem2dc_stcomplete,
    output logic                              anycore_core_reset,
    output logic                              anycore_spurious_resp
);

    enc_state_e                        state_q, state_d;
    logic                              take_resp, fill_cap, fill_spur, ld_cap, st_cap, int_wake;
    logic                              fill_pending;
    logic [ICACHE_BLOCK_ADDR_BITS-1:0] miss_addr;
    logic [RESP_DATA_BITS-1:0]         resp_data;

    anycore_fill_tracker u_fill_tracker (
        .clk       (clk),
        .rst       (rst),
        .req_set   (anycore_ic2mem_reqvalid),
        .req_addr  (anycore_ic2mem_reqaddr),
        .fill_clr  (fill_cap),
        .pending   (fill_pending),
        .miss_addr (miss_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_INT;
        else     state_q <= state_d;
    end

    // Wake-up clears core_reset on the same edge that enters ACK, so ACK can
    // pick its successor from the already-updated flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_INT: if (l15_transducer_val) state_d = ACK;
            IDLE:     if (l15_transducer_val) state_d = ACK;
            ACK:      state_d = anycore_core_reset ? WAIT_INT : IDLE;
            default:  state_d = WAIT_INT;
        endcase
    end

    always_comb begin
        transducer_l15_req_ack = (state_q == ACK);
        take_resp = l15_transducer_val && (state_q == IDLE);
        fill_cap  = take_resp && (l15_transducer_returntype == IFILL_RET) && fill_pending;
        fill_spur = take_resp && (l15_transducer_returntype == IFILL_RET) && !fill_pending;
        ld_cap    = take_resp && (l15_transducer_returntype == LOAD_RET);
        st_cap    = take_resp && (l15_transducer_returntype == ST_ACK);
        int_wake  = l15_transducer_val && (state_q == WAIT_INT)
                    && (l15_transducer_returntype == INT_RET);
        resp_data = pack_resp(l15_transducer_data_0, l15_transducer_data_1,
                              l15_transducer_data_2, l15_transducer_data_3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anycore_mem2ic_respvalid  <= 1'b0;
            anycore_mem2ic_respaddr   <= '0;
            anycore_mem2ic_data       <= '0;
            anycore_mem2dc_ldvalid    <= 1'b0;
            anycore_mem2dc_lddata     <= '0;
            anycore_mem2dc_stcomplete <= 1'b0;
            anycore_core_reset        <= 1'b1;
            anycore_spurious_resp     <= 1'b0;
        end else begin
            anycore_mem2ic_respvalid  <= fill_cap;
            anycore_mem2dc_ldvalid    <= ld_cap;
            anycore_mem2dc_stcomplete <= st_cap;
            if (fill_cap) begin
                anycore_mem2ic_respaddr <= miss_addr;
                anycore_mem2ic_data     <= resp_data;
            end
            if (ld_cap)    anycore_mem2dc_lddata <= resp_data;
            if (int_wake)  anycore_core_reset    <= 1'b0;
            if (fill_spur) anycore_spurious_resp <= 1'b1;
        end
    end

endmodule

// File: doc/anycore_encoder.md
ANYCORE_ENCODER -- requirements
Module: anycore_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port l15_transducer_val, input, 1, L1.5 response valid; held by L1.5 until acked.
REQ-004 SHALL have port l15_transducer_returntype, input, 4, response type, codes per iop.h.
REQ-005 SHALL have ports l15_transducer_data_0..3, input, 64 each, response payload.
REQ-006 SHALL have port anycore_ic2mem_reqaddr, input, `ICACHE_BLOCK_ADDR_BITS, I-miss block address.
REQ-007 SHALL have port anycore_ic2mem_reqvalid, input, 1, I-miss issue strobe.
REQ-008 SHALL have port transducer_l15_req_ack, output, 1, response consumed.
REQ-009 SHALL have port anycore_mem2ic_respvalid, output, 1, I-fill pulse.
REQ-010 SHALL have port anycore_mem2ic_respaddr, output, `ICACHE_BLOCK_ADDR_BITS, address of returned fill.
REQ-011 SHALL have port anycore_mem2ic_data, output, 256, fill data = {data_3,data_2,data_1,data_0}.
REQ-012 SHALL have port anycore_mem2dc_ldvalid, output, 1, load-return pulse.
REQ-013 SHALL have port anycore_mem2dc_lddata, output, 256, load data, same packing as REQ-011.
REQ-014 SHALL have port anycore_mem2dc_stcomplete, output, 1, store-ack pulse.
REQ-015 SHALL have port anycore_core_reset, output, 1, holds core in reset until wake-up.
REQ-016 SHALL have port anycore_spurious_resp, output, 1, sticky error flag.

Function
REQ-017 SHALL implement FSM states WAIT_INT, IDLE, ACK.
REQ-018 WAIT_INT: on val with returntype INT_RET -> ACK, anycore_core_reset deasserts the following cycle; on any other returntype -> ACK, response dropped, no anycore pulse.
REQ-019 IDLE: on val -> ACK, response captured into output registers.
REQ-020 ACK: transducer_l15_req_ack=1 for exactly this one cycle; next state IDLE (or WAIT_INT if core still in reset); val is not sampled in ACK.
REQ-021 Latency: val sampled at cycle N -> anycore pulse and ack both at N+1; next response acceptable at N+2.
REQ-022 All anycore valid/complete outputs SHALL be single-cycle pulses; data/addr outputs hold last captured value.
REQ-023 IFILL_RET with fill outstanding -> respvalid pulse, respaddr = latched miss address, outstanding cleared.
REQ-024 IFILL_RET with none outstanding -> acked, no respvalid, anycore_spurious_resp set.
REQ-025 LOAD_RET -> ldvalid pulse; ST_ACK -> stcomplete pulse.
REQ-026 INV_RET, EVICT_REQ, INT_RET in IDLE, unknown codes -> acked, no anycore pulse.
REQ-027 ic2mem_reqvalid with none outstanding -> latch reqaddr, set outstanding.
REQ-028 ic2mem_reqvalid while outstanding (no fill capture that cycle) -> ignored, latched address unchanged.
REQ-029 ic2mem_reqvalid in same cycle as IFILL_RET capture -> set wins: new address latched, outstanding stays 1, completing fill reports old address.
REQ-030 anycore_spurious_resp SHALL clear only on reset.

Reset
REQ-031 On rst: state WAIT_INT, anycore_core_reset=1, outstanding=0, all pulses/ack=0, data/addr outputs=0, spurious=0.
REQ-032 rst mid-response (any state) SHALL abandon it without ack; L1.5 re-presents after reset.

Structure
REQ-033 Returntype codes SHALL come from iop.h; block widths from CommonConfig.h; FSM encoding local.
REQ-034 Outstanding-miss register and set/clear priority SHALL be sub-module anycore_fill_tracker.

Verification
REQ-035 Reset, then IFILL_RET(4'b0001) before INT_RET -> ack at N+1, no respvalid, core_reset stays 1.
REQ-036 INT_RET(4'b0111) at N -> ack at N+1, core_reset=0 from N+1.
REQ-037 reqaddr=0x1234 reqvalid, then IFILL_RET data_0..3=0xA..0xD -> respvalid N+1, respaddr 0x1234, data {D,C,B,A}.
REQ-038 ST_ACK(4'b0100) and LOAD_RET(4'b0000) back-to-back, val held -> stcomplete at N+1, ldvalid at N+3, two acks.
REQ-039 reqvalid addr 0x55 same cycle as fill capture for 0x1234 -> respaddr 0x1234, then next fill reports 0x55.
REQ-040 IFILL_RET with nothing outstanding -> spurious=1, persists until rst.
